output_accumulator: RTL and testbench
=====================================

OUTPUT_ACCUMULATOR -- requirements
Module: output_accumulator

Interface
REQ-001 Parameter DATA_WIDTH, default 12: signed width of each requantized output lane, which feeds the Tanh stage input.
REQ-002 Parameter SA_LENGTH, default 8: number of lanes (systolic array columns).
REQ-003 Parameter S, default 7: fractional bits of the output format. Input partial sums carry 2*S fractional bits.
REQ-004 Parameter ACC_WIDTH, default 32: signed width of the input partial sums and of each accumulator.
REQ-005 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 in_valid  input  1  psum and in_last are valid this cycle.
REQ-009 in_ready  output  1  block accepts a beat this cycle.
REQ-010 psum  input  SA_LENGTH x ACC_WIDTH signed (unpacked array)  per-lane partial sums from the systolic array.
REQ-011 in_last  input  1  marks the final beat of the current accumulation group.
REQ-012 out_valid  output  1  out holds a completed group.
REQ-013 out_ready  input  1  downstream (Tanh stage) consumes out.
REQ-014 out  output  SA_LENGTH x DATA_WIDTH signed (unpacked array)  registered requantized results.
REQ-015 beat_cnt  output  8  number of beats accepted in the current group.
REQ-016 acc_ovf  output  1  sticky flag: some accumulator saturated.

Function
REQ-017 The block SHALL be a two-state FSM with states ACCUM and HOLD.
REQ-018 In ACCUM, in_ready SHALL be 1. In HOLD, in_ready SHALL be 0.
REQ-019 A beat SHALL be accepted only in a cycle where in_valid && in_ready.
REQ-020 Accepted first beat of a group: acc[i] = psum[i]. Later beats: acc[i] = sat_ACC(acc[i] + psum[i]).
REQ-021 Accumulator addition SHALL be computed at ACC_WIDTH+1 bits and clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. Any clamp SHALL set acc_ovf, which stays 1 until rst.
REQ-022 beat_cnt SHALL increment by 1 per accepted beat, saturating at 255. It SHALL return to 0 when the group completes.
REQ-023 An accepted beat with in_last=1 SHALL register out[i] = requant(updated acc[i]), set out_valid=1, and move the FSM to HOLD. The latency is one cycle from the last beat edge to out_valid high.
REQ-024 A single-beat group (first beat with in_last=1) SHALL be legal; requant then uses psum directly.
REQ-025 requant(a) = sat_DW((a + 2^(S-1)) >>> S). The rounding add SHALL be done at ACC_WIDTH+1 bits, so rounding is half-up toward +infinity.
REQ-026 sat_DW SHALL clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], which is [-2048, 2047] at the default width.
REQ-027 In HOLD, out and out_valid SHALL stay stable until out_ready=1.
REQ-028 In HOLD with out_ready=1, the block SHALL clear out_valid, return to ACCUM, and mark the next beat as a group first beat.
REQ-029 There SHALL be no bypass: in the cycle out_ready clears HOLD, in_ready is still 0, and the next beat is accepted one cycle later at the earliest.
REQ-030 out SHALL retain its last value after out_valid falls.
REQ-031 in_valid while in_ready=0 SHALL have no effect. Upstream holds the beat.

Reset
REQ-032 When rst=1 at an edge, the block SHALL set: state=ACCUM; out_valid=0; out all 0; all acc 0; beat_cnt=0; acc_ovf=0; next beat marked as first.
REQ-033 rst SHALL take priority over any simultaneous handshake.
REQ-034 rst mid-group or in HOLD SHALL discard the partial group and pending output with no out_valid pulse.
REQ-035 While rst=1, in_ready SHALL be 1 combinationally (state ACCUM), but no beat is accepted.

Verification
REQ-036 Single beat: psum lanes = {0, 51200, 66176, -65536, -65, 64, 63, -64}, in_last=1 -> next cycle out_valid=1, out = {0, 400, 517, -512, -1, 1, 0, 0}, beat_cnt=0.
REQ-037 Three-beat group: psum lane0 = 12800 each beat, in_last on beat 3 -> beat_cnt 1, 2, then out[0]=300. Lanes at 300000 and -300000 -> out 2047 and -2048 (output saturation), acc_ovf=0.
REQ-038 Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out stable; out_ready=1 -> out_valid=0 next cycle; next beat accepted the following cycle as a fresh group.
REQ-039 Accumulator overflow: two beats of 2^31-1 on lane0 -> acc clamps to 2^31-1, acc_ovf=1, out[0]=2047; acc_ovf stays 1 across later groups until rst.
REQ-040 Reset mid-group: two beats accepted, then rst=1 for one cycle, then a single in_last beat of 128 -> out[0]=1, with no contribution from the discarded beats and beat_cnt=0 after reset.

Source files
------------

// File: rtl/output_accumulator_if.sv
// rtl/output_accumulator_if.sv - beat input and group output handshake bundle for output_accumulator
interface output_accumulator_if #(
    parameter int DATA_WIDTH = 12,
    parameter int SA_LENGTH  = 8,
    parameter int ACC_WIDTH  = 32
);
    logic                         in_valid;
    logic                         in_ready;
    logic                         in_last;
    logic signed [ACC_WIDTH-1:0]  psum [SA_LENGTH];
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out  [SA_LENGTH];

    modport master (
        output in_valid, in_last, psum, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, in_last, psum, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/output_accumulator.sv
// rtl/output_accumulator.sv - per-lane saturating psum accumulator with rounded requantization to the Tanh input format
module output_accumulator #(
    parameter int DATA_WIDTH = 12,
    parameter int SA_LENGTH  = 8,
    parameter int S          = 7,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    output_accumulator_if.slave  bus,
    output logic [7:0]           beat_cnt,
    output logic                 acc_ovf
);
    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic signed [ACC_WIDTH:0] ACC_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] ACC_MIN = {2'b11, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH:0] RND     = {{(ACC_WIDTH+1-S){1'b0}}, 1'b1, {(S-1){1'b0}}};
    localparam logic signed [ACC_WIDTH:0] DW_MAX  = {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] DW_MIN  = {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    state_t                       state, next_state;
    logic                         first;
    logic                         accept;
    logic signed [ACC_WIDTH-1:0]  acc     [SA_LENGTH];
    logic signed [ACC_WIDTH:0]    sum_w   [SA_LENGTH];
    logic signed [ACC_WIDTH-1:0]  acc_upd [SA_LENGTH];
    logic signed [ACC_WIDTH:0]    rnd_w   [SA_LENGTH];
    logic signed [ACC_WIDTH:0]    shf_w   [SA_LENGTH];
    logic signed [DATA_WIDTH-1:0] rq      [SA_LENGTH];
    logic [SA_LENGTH-1:0]         lane_ovf;

    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= next_state;
    end

    // in_ready is forced high during reset so upstream sees the post-reset ACCUM view immediately
    always_comb begin
        next_state   = state;
        bus.in_ready = rst || (state == ACCUM);
        accept       = bus.in_valid && bus.in_ready && !rst;
        case (state)
            ACCUM:   if (accept && bus.in_last) next_state = HOLD;
            HOLD:    if (bus.out_ready)         next_state = ACCUM;
            default: next_state = ACCUM;
        endcase
    end

    always_comb begin
        for (int i = 0; i < SA_LENGTH; i++) begin
            if (first)
                sum_w[i] = {bus.psum[i][ACC_WIDTH-1], bus.psum[i]};
            else
                sum_w[i] = {acc[i][ACC_WIDTH-1], acc[i]} + {bus.psum[i][ACC_WIDTH-1], bus.psum[i]};
            lane_ovf[i] = sum_w[i][ACC_WIDTH] != sum_w[i][ACC_WIDTH-1];
            if (lane_ovf[i])
                acc_upd[i] = sum_w[i][ACC_WIDTH] ? ACC_MIN[ACC_WIDTH-1:0] : ACC_MAX[ACC_WIDTH-1:0];
            else
                acc_upd[i] = sum_w[i][ACC_WIDTH-1:0];
            // one extra bit keeps the rounding add from wrapping near the positive limit
            rnd_w[i] = {acc_upd[i][ACC_WIDTH-1], acc_upd[i]} + RND;
            shf_w[i] = rnd_w[i] >>> S;
            if (shf_w[i] > DW_MAX)
                rq[i] = DW_MAX[DATA_WIDTH-1:0];
            else if (shf_w[i] < DW_MIN)
                rq[i] = DW_MIN[DATA_WIDTH-1:0];
            else
                rq[i] = shf_w[i][DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            first         <= 1'b1;
            beat_cnt      <= 8'd0;
            acc_ovf       <= 1'b0;
            for (int i = 0; i < SA_LENGTH; i++) begin
                acc[i]     <= '0;
                bus.out[i] <= '0;
            end
        end else if (accept) begin
            first <= bus.in_last;
            for (int i = 0; i < SA_LENGTH; i++) acc[i] <= acc_upd[i];
            if (|lane_ovf) acc_ovf <= 1'b1;
            if (bus.in_last) begin
                for (int i = 0; i < SA_LENGTH; i++) bus.out[i] <= rq[i];
                bus.out_valid <= 1'b1;
                beat_cnt      <= 8'd0;
            end else if (beat_cnt != 8'hff) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
        end else if (state == HOLD && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_output_accumulator.sv
// tb/tb_output_accumulator.sv - directed-vector self-checking bench for output_accumulator
module tb_output_accumulator;
    logic       clk;
    logic       rst;
    logic [7:0] beat_cnt;
    logic       acc_ovf;
    int         n_checks;
    int         n_fail;

    output_accumulator_if #(.DATA_WIDTH(12), .SA_LENGTH(8), .ACC_WIDTH(32)) bus ();

    output_accumulator #(.DATA_WIDTH(12), .SA_LENGTH(8), .S(7), .ACC_WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .beat_cnt (beat_cnt),
        .acc_ovf  (acc_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load(input int v0, input int v1, input int v2, input int v3,
                        input int v4, input int v5, input int v6, input int v7);
        bus.psum[0] = v0; bus.psum[1] = v1; bus.psum[2] = v2; bus.psum[3] = v3;
        bus.psum[4] = v4; bus.psum[5] = v5; bus.psum[6] = v6; bus.psum[7] = v7;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic last);
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b0;
        load(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_beat_cnt", beat_cnt, 0);
        check("rst_acc_ovf", acc_ovf, 0);
        check("rst_out0", bus.out[0], 0);
        rst = 1'b0;
        tick();

        // single-beat group with rounding corner cases
        load(0, 51200, 66176, -65536, -65, 64, 63, -64);
        beat(1'b1);
        check("single_valid", bus.out_valid, 1);
        check("single_out0", bus.out[0], 0);
        check("single_out1", bus.out[1], 400);
        check("single_out2", bus.out[2], 517);
        check("single_out3", bus.out[3], -512);
        check("single_out4", bus.out[4], -1);
        check("single_out5", bus.out[5], 1);
        check("single_out6", bus.out[6], 0);
        check("single_out7", bus.out[7], 0);
        check("single_beat_cnt", beat_cnt, 0);
        check("hold_in_ready", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        #1;
        check("release_cycle_in_ready", bus.in_ready, 0);
        tick();
        bus.out_ready = 1'b0;
        check("release_out_valid", bus.out_valid, 0);
        check("release_in_ready", bus.in_ready, 1);
        check("retain_out1", bus.out[1], 400);

        // three-beat group with output saturation
        load(12800, 300000, -300000, 0, 0, 0, 0, 0);
        beat(1'b0);
        check("grp_beat_cnt1", beat_cnt, 1);
        beat(1'b0);
        check("grp_beat_cnt2", beat_cnt, 2);
        check("grp_no_valid", bus.out_valid, 0);
        beat(1'b1);
        check("grp_valid", bus.out_valid, 1);
        check("grp_out0", bus.out[0], 300);
        check("grp_out1_sat", bus.out[1], 2047);
        check("grp_out2_sat", bus.out[2], -2048);
        check("grp_acc_ovf", acc_ovf, 0);
        check("grp_beat_cnt0", beat_cnt, 0);

        // backpressure while upstream keeps offering a beat
        load(1280, 0, 0, 0, 0, 0, 0, 0);
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_out0", bus.out[0], 300);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_release_valid", bus.out_valid, 0);
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check("bp_fresh_valid", bus.out_valid, 1);
        check("bp_fresh_out0", bus.out[0], 10);
        release_out();

        // accumulator saturation in both directions
        load(32'h7fffffff, 32'h80000000, 0, 0, 0, 0, 0, 0);
        beat(1'b0);
        check("ovf_first_flag", acc_ovf, 0);
        beat(1'b1);
        check("ovf_flag", acc_ovf, 1);
        check("ovf_out0", bus.out[0], 2047);
        check("ovf_out1", bus.out[1], -2048);
        release_out();
        load(128, 0, 0, 0, 0, 0, 0, 0);
        beat(1'b1);
        check("ovf_next_out0", bus.out[0], 1);
        check("ovf_sticky", acc_ovf, 1);
        release_out();

        // reset mid-group, with a beat offered during reset
        load(1000, 0, 0, 0, 0, 0, 0, 0);
        beat(1'b0);
        beat(1'b0);
        check("mid_beat_cnt", beat_cnt, 2);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        check("mid_rst_in_ready", bus.in_ready, 1);
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check("mid_rst_beat_cnt", beat_cnt, 0);
        check("mid_rst_acc_ovf", acc_ovf, 0);
        check("mid_rst_out0", bus.out[0], 0);
        load(128, 0, 0, 0, 0, 0, 0, 0);
        beat(1'b1);
        check("mid_after_out0", bus.out[0], 1);
        check("mid_after_beat_cnt", beat_cnt, 0);

        // reset while holding drops the pending output
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("hold_rst_valid", bus.out_valid, 0);
        check("hold_rst_out0", bus.out[0], 0);
        tick();
        check("hold_rst_stays_low", bus.out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
